// File: rtl/stall_ctrl_pkg.sv
// Shared constants, types and the operand hazard check for the stall controller.
package stall_ctrl_pkg;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned TUSE_W      = 3;
  localparam int unsigned MD_CNT_W    = 4;
  localparam int unsigned STALL_CNT_W = 32;

  // Operand is not read by the decode instruction
  localparam logic [TUSE_W-1:0]   TUSE_NONE      = 3'b111;
  // Busy window length after the start cycle
  localparam logic [MD_CNT_W-1:0] MD_MULT_CYCLES = 4'd5;
  localparam logic [MD_CNT_W-1:0] MD_DIV_CYCLES  = 4'd10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Register-write view of one downstream pipeline stage
  typedef struct packed {
    logic              reg_write;
    logic [REG_W-1:0]  write_reg;
    logic [TUSE_W-1:0] tnew;
  } stage_wr_t;

  // A source operand must wait when a younger-than-needed result targets it.
  // Writes to $0 never hazard because src == 0 is excluded.
  function automatic logic operand_hazard(input logic [REG_W-1:0]  src,
                                          input logic [TUSE_W-1:0] tuse,
                                          input stage_wr_t         e,
                                          input stage_wr_t         m);
    logic e_hit;
    logic m_hit;
    e_hit = e.reg_write && (e.write_reg == src) && (e.tnew > tuse);
    m_hit = m.reg_write && (m.write_reg == src) && (m.tnew > tuse);
    return (tuse != TUSE_NONE) && (src != '0) && (e_hit || m_hit);
  endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// Decode/execute/memory hazard inputs and stall outputs of the stall controller.
// master: pipeline side (drives stage info, reads stall); slave: stall_ctrl.
interface stall_ctrl_if;
  import stall_ctrl_pkg::*;

  logic [REG_W-1:0]       D_Rs;
  logic [REG_W-1:0]       D_Rt;
  logic [TUSE_W-1:0]      D_TUseRs;
  logic [TUSE_W-1:0]      D_TUseRt;
  logic                   D_IsMD;
  logic [REG_W-1:0]       E_WriteReg;
  logic                   E_RegWrite;
  logic [TUSE_W-1:0]      E_TNew;
  logic [REG_W-1:0]       M_WriteReg;
  logic                   M_RegWrite;
  logic [TUSE_W-1:0]      M_TNew;
  logic                   E_MDStart;
  logic                   E_MDIsDiv;
  logic                   Stall;
  logic                   E_Flush;
  logic                   MDBusy;
  logic [STALL_CNT_W-1:0] StallCount;

  modport master (
    output D_Rs, D_Rt, D_TUseRs, D_TUseRt, D_IsMD,
    output E_WriteReg, E_RegWrite, E_TNew,
    output M_WriteReg, M_RegWrite, M_TNew,
    output E_MDStart, E_MDIsDiv,
    input  Stall, E_Flush, MDBusy, StallCount
  );

  modport slave (
    input  D_Rs, D_Rt, D_TUseRs, D_TUseRt, D_IsMD,
    input  E_WriteReg, E_RegWrite, E_TNew,
    input  M_WriteReg, M_RegWrite, M_TNew,
    input  E_MDStart, E_MDIsDiv,
    output Stall, E_Flush, MDBusy, StallCount
  );

endinterface

// File: rtl/stall_ctrl_md_busy_timer.sv
// Multiply/divide occupancy timer.
// Ports: Clk, Reset (sync, active-high), Start (mult/div in E), IsDiv (1 = div),
//        Busy (combinational: Start or countdown running).
module md_busy_timer
  import stall_ctrl_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  input  logic IsDiv,
  output logic Busy
);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

  // State and counter registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Load on start from idle; starts seen while busy are ignored
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (Start) begin
          cnt_d   = IsDiv ? MD_DIV_CYCLES : MD_MULT_CYCLES;
          state_d = MD_BUSY;
        end
      end
      MD_BUSY: begin
        cnt_d = MD_CNT_W'(cnt_q - 1'b1);
        if (cnt_q == MD_CNT_W'(1)) begin
          state_d = MD_IDLE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Start cycle itself counts as busy
  assign Busy = Start || (cnt_q != '0);

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: data hazards on rs/rt against E/M writers plus
// multiply/divide occupancy; Stall/E_Flush are combinational, StallCount saturates.
// Ports: Clk, Reset (sync, active-high), bus (stall_ctrl_if.slave).
module stall_ctrl
  import stall_ctrl_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  stall_ctrl_if.slave  bus
);

  stage_wr_t              e_wr;
  stage_wr_t              m_wr;
  logic                   hz_rs;
  logic                   hz_rt;
  logic                   hz_md;
  logic                   md_busy;
  logic                   stall_c;
  logic [STALL_CNT_W-1:0] stall_count_q;

  assign e_wr = '{reg_write: bus.E_RegWrite, write_reg: bus.E_WriteReg, tnew: bus.E_TNew};
  assign m_wr = '{reg_write: bus.M_RegWrite, write_reg: bus.M_WriteReg, tnew: bus.M_TNew};

  md_busy_timer u_md_busy_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (bus.E_MDStart),
    .IsDiv (bus.E_MDIsDiv),
    .Busy  (md_busy)
  );

  // Hazard detection; no reset override so a reset cycle still stalls on hazards
  always_comb begin
    hz_rs   = operand_hazard(bus.D_Rs, bus.D_TUseRs, e_wr, m_wr);
    hz_rt   = operand_hazard(bus.D_Rt, bus.D_TUseRt, e_wr, m_wr);
    hz_md   = bus.D_IsMD && md_busy;
    stall_c = hz_rs || hz_rt || hz_md;
  end

  // Saturating stalled-cycle counter
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_count_q <= '0;
    end else if (stall_c && (stall_count_q != '1)) begin
      stall_count_q <= STALL_CNT_W'(stall_count_q + 1'b1);
    end
  end

  assign bus.Stall      = stall_c;
  assign bus.E_Flush    = stall_c;
  assign bus.MDBusy     = md_busy;
  assign bus.StallCount = stall_count_q;

endmodule
